// File: rtl/inv_shift_rows_stream.sv
// inv_shift_rows_stream
//   Byte-serial AES (Inv)ShiftRows stage. A 16-byte state arrives in
//   column-major order and is stored in one of NUM_BANKS ping-pong buffers.
//   Once the buffer is full it is replayed in the same order with row r
//   rotated right by r.
//   Optional feature macro: SHIFT_ROWS_FWD_EN adds a per-block 'fwd' input
//   that selects forward ShiftRows (rotate left) instead of InvShiftRows.
//
//   bank state | meaning
//   EMPTY      | free, next write starts a block here
//   FILLING    | 1..15 bytes written
//   FULL       | 16 bytes written, no byte read yet
//   DRAINING   | 1..15 bytes read out
module inv_shift_rows_stream #(
  parameter int NUM_BANKS = 2,
  parameter int BYTE_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_last,
`ifdef SHIFT_ROWS_FWD_EN
  input  logic              fwd,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic              err
);

  localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [PW-1:0] LAST_BANK = PW'(NUM_BANKS - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  if (BYTE_W != 8) begin : g_bad_width
    $error("inv_shift_rows_stream: BYTE_W must be 8");
  end
  if (NUM_BANKS < 1) begin : g_bad_banks
    $error("inv_shift_rows_stream: NUM_BANKS must be at least 1");
  end

  bank_state_t       state     [NUM_BANKS];
  bank_state_t       state_nxt [NUM_BANKS];
  logic [BYTE_W-1:0] mem       [NUM_BANKS][16];
  logic [PW-1:0]     wr_bank, rd_bank;
  logic [3:0]        wr_cnt, rd_cnt;
  bank_state_t       wr_state, rd_state;
  logic              wr_fire, rd_fire;
  logic              rd_fwd;
  logic [1:0]        row, col, src_col;
  logic [3:0]        src;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_BANK) ? '0 : p + 1'b1;
  endfunction

  assign wr_state = state[wr_bank];
  assign rd_state = state[rd_bank];
  assign s_ready  = (wr_state == EMPTY) || (wr_state == FILLING);
  assign m_valid  = (rd_state == FULL) || (rd_state == DRAINING);
  assign wr_fire  = s_valid && s_ready;
  assign rd_fire  = m_valid && m_ready;

  // Output byte k = (row k%4, col k/4) is fetched from column col -/+ row.
  assign row     = rd_cnt[1:0];
  assign col     = rd_cnt[3:2];
  assign src_col = rd_fwd ? (col + row) : (col - row);
  assign src     = {src_col, row};
  assign m_data  = m_valid ? mem[rd_bank][src] : '0;
  assign m_last  = m_valid && (rd_cnt == 4'd15);

`ifdef SHIFT_ROWS_FWD_EN
  logic [NUM_BANKS-1:0] bank_fwd;

  assign rd_fwd = bank_fwd[rd_bank];

  // Direction is captured with byte 0 and follows its block through the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_fwd <= '0;
    end else if (wr_fire && (wr_cnt == 4'd0)) begin
      bank_fwd[wr_bank] <= fwd;
    end
  end
`else
  assign rd_fwd = 1'b0;
`endif

  // Bank lifecycle: write side and read side never own the same bank at once.
  always_comb begin
    state_nxt = state;
    if (wr_fire) begin
      state_nxt[wr_bank] = (wr_cnt == 4'd15) ? FULL : FILLING;
    end
    if (rd_fire) begin
      state_nxt[rd_bank] = (rd_cnt == 4'd15) ? EMPTY : DRAINING;
    end
  end

  // Bank state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) state[b] <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Byte storage, cleared on reset so nothing stale is ever replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < 16; i++) mem[b][i] <= '0;
    end else if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= s_data;
    end
  end

  // Write counter and pointer; the counter alone defines block framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= '0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 4'd1;
      if (wr_cnt == 4'd15) wr_bank <= next_ptr(wr_bank);
    end
  end

  // Read counter and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= '0;
    end else if (rd_fire) begin
      rd_cnt <= rd_cnt + 4'd1;
      if (rd_cnt == 4'd15) rd_bank <= next_ptr(rd_bank);
    end
  end

  // Sticky framing error: s_last must coincide exactly with byte 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (wr_fire && (s_last != (wr_cnt == 4'd15))) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Bench for inv_shift_rows_stream: a 2-bank instance driven through a
// scoreboard queue, plus a 1-bank instance for the half-throughput handshake.
module tb_inv_shift_rows_stream;

  typedef logic [7:0] blk_t [16];

  logic       clk;
  logic       rst_n;
  logic       s_valid, s_ready, s_last;
  logic [7:0] s_data;
  logic       m_valid, m_ready, m_last, err;
  logic [7:0] m_data;
  logic       s1_valid, s1_ready, s1_last;
  logic [7:0] s1_data;
  logic       m1_valid, m1_ready, m1_last, err1;
  logic [7:0] m1_data;
`ifdef SHIFT_ROWS_FWD_EN
  logic       fwd;
`endif

  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         stall_cnt = 0;
  int         xfer_cnt = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  bit         rand_ready = 0;
  logic [8:0] exp_q [$];

  inv_shift_rows_stream #(.NUM_BANKS(2), .BYTE_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
`ifdef SHIFT_ROWS_FWD_EN
    .fwd(fwd),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err)
  );

  inv_shift_rows_stream #(.NUM_BANKS(1), .BYTE_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data), .s_last(s1_last),
`ifdef SHIFT_ROWS_FWD_EN
    .fwd(1'b0),
`endif
    .m_valid(m1_valid), .m_ready(m1_ready), .m_data(m1_data), .m_last(m1_last),
    .err(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference permutation written directly from the row-rotation definition.
  function automatic logic [7:0] perm_byte(input blk_t b, input int k, input bit fwd_m);
    int r, c, sc;
    r  = k % 4;
    c  = k / 4;
    sc = fwd_m ? (c + r) % 4 : (c + 4 - r) % 4;
    return b[4 * sc + r];
  endfunction

  function automatic void push_model(input blk_t b, input bit fwd_m);
    for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), perm_byte(b, k, fwd_m)});
  endfunction

  function automatic void push_table(input blk_t t);
    for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), t[k]});
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int k = 0; k < 16; k++) b[k] = 8'($urandom_range(0, 255));
    return b;
  endfunction

  // Downstream ready for the 2-bank instance, changed just after each edge.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on transfer, hold check while stalled.
  initial begin
    bit         have_prev;
    logic [7:0] prev_d;
    logic       prev_l;
    logic [8:0] e;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 0;
      end else begin
        if (have_prev) begin
          chk("hold_valid", m_valid, 1'b1);
          chk("hold_data", m_data, prev_d);
          chk("hold_last", m_last, prev_l);
        end
        have_prev = m_valid && !m_ready;
        prev_d    = m_data;
        prev_l    = m_last;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_output", m_data, 8'h00);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", m_data, e[7:0]);
            chk("m_last", m_last, e[8]);
          end
          if (xfer_cnt == 0) first_cyc = cyc;
          last_cyc = cyc;
          xfer_cnt++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    logic acc;
    int   n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_ready;
      if (!acc) stall_cnt++;
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("s_ready_timeout", acc, 1'b1);
    #1;
  endtask

  task automatic send1_byte(input logic [7:0] d, input logic l);
    logic acc;
    int   n;
    s1_valid = 1'b1;
    s1_data  = d;
    s1_last  = l;
    n = 0;
    do begin
      @(negedge clk);
      acc = s1_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("s1_ready_timeout", acc, 1'b1);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1 chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    blk_t b;
    blk_t t1;
    int   k, n;
    t1 = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
           8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; m1_ready = 1'b0;
`ifdef SHIFT_ROWS_FWD_EN
    fwd = 1'b0;
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m1_valid", m1_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_s1_ready", s1_ready, 1'b1);

    // known vector and 1-clk latency
    push_table(t1);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), (i == 15));
      if (i == 14) chk("t1_valid_early", m_valid, 1'b0);
    end
    chk("t1_latency", m_valid, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_drain();

    // four back-to-back blocks at full rate
    stall_cnt = 0;
    xfer_cnt  = 0;
    for (int blk = 0; blk < 4; blk++) begin
      b = rand_blk();
      push_model(b, 1'b0);
      for (int i = 0; i < 16; i++) send_byte(b[i], (i == 15));
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_drain();
    chk("b2b_s_ready_low", stall_cnt, 0);
    chk("b2b_count", xfer_cnt, 64);
    chk("b2b_span", last_cyc - first_cyc, 63);

    // random downstream backpressure
    rand_ready = 1;
    for (int blk = 0; blk < 3; blk++) begin
      b = rand_blk();
      push_model(b, 1'b0);
      for (int i = 0; i < 16; i++) send_byte(b[i], (i == 15));
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_drain();
    rand_ready = 0;
    chk("bp_err", err, 1'b0);

    // s_last on byte 7: sticky err, data unaffected
    b = rand_blk();
    push_model(b, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_byte(b[i], (i == 7) || (i == 15));
      if (i == 6) chk("err_before", err, 1'b0);
      if (i == 7) chk("err_set", err, 1'b1);
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_drain();
    chk("err_sticky", err, 1'b1);

    // reset mid-block drops the partial state and clears err
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_m_data", m_data, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_m_valid", m_valid, 1'b0);
    b = rand_blk();
    push_model(b, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(b[i], (i == 15));
    s_valid = 1'b0; s_last = 1'b0;
    wait_drain();
    chk("post_rst_err", err, 1'b0);

    // single bank: input blocked until the clk after m_last is taken
    b = rand_blk();
    for (int i = 0; i < 16; i++) send1_byte(b[i], (i == 15));
    s1_valid = 1'b0; s1_last = 1'b0;
    chk("nb1_s_ready_full", s1_ready, 1'b0);
    chk("nb1_m_valid", m1_valid, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("nb1_s_ready_hold", s1_ready, 1'b0);
    k = 0;
    n = 0;
    while (k < 16 && n < 400) begin
      @(posedge clk);
      #1 m1_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (m1_valid && m1_ready) begin
        chk("nb1_data", m1_data, perm_byte(b, k, 1'b0));
        chk("nb1_last", m1_last, (k == 15));
        chk("nb1_s_ready_drain", s1_ready, 1'b0);
        k++;
      end
    end
    chk("nb1_count", k, 16);
    @(posedge clk);
    #1;
    m1_ready = 1'b0;
    chk("nb1_s_ready_back", s1_ready, 1'b1);
    chk("nb1_m_valid_done", m1_valid, 1'b0);
    chk("nb1_err", err1, 1'b0);

`ifdef SHIFT_ROWS_FWD_EN
    // forward ShiftRows, then inverse of that result restores the input
    b = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
          8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    push_table(b);
    fwd = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(i), (i == 15));
    fwd = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), 8'(i)});
    for (int i = 0; i < 16; i++) send_byte(b[i], (i == 15));
    s_valid = 1'b0; s_last = 1'b0;
    wait_drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t passed=%0d checks=%0d", $time, n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
